// File: rtl/rtc_update_sched_if.sv
// rtc_update_sched_if: update triggers, datapath op handshake and status between
// the register block / counter synchroniser, the scheduler and the update datapath.
interface rtc_update_sched_if #(
    parameter int LOST_W = 8
);
    logic              WrenRTCLR;
    logic              CountEdge;
    logic              WrenRTCMR;
    logic              OpDone;
    logic              ErrClr;
    logic              OpValid;
    logic [1:0]        OpSel;
    logic              Busy;
    logic              TimeoutErr;
    logic [LOST_W-1:0] LostCnt;

    modport master (
        output WrenRTCLR, CountEdge, WrenRTCMR, OpDone, ErrClr,
        input  OpValid, OpSel, Busy, TimeoutErr, LostCnt
    );

    modport slave (
        input  WrenRTCLR, CountEdge, WrenRTCMR, OpDone, ErrClr,
        output OpValid, OpSel, Busy, TimeoutErr, LostCnt
    );
endinterface

// File: rtl/rtc_update_sched.sv
// rtc_update_sched: fixed-priority scheduler for the shared RTC update adder (offset > RTC value > match).
// Optional coalesced-CountEdge counter enabled by RTC_SCHED_LOSTCNT_EN.
module rtc_update_sched #(
    parameter int TIMEOUT = 16,
    parameter int LOST_W  = 8
) (
    input logic               PCLK,
    input logic               nPOR,
    rtc_update_sched_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [1:0] OP_NONE = 2'b00, OP_LD = 2'b01, OP_CNT = 2'b10, OP_MT = 2'b11;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, stateNext;
    logic          ldPend, cntPend, mtPend;
    logic          ldPendNext, cntPendNext, mtPendNext;
    logic          opValid, opValidNext;
    logic [1:0]    opSel, opSelNext, launchSel;
    logic          timeoutErr, timeoutErrNext;
    logic [TW-1:0] timer, timerNext;
    logic          launch, done, abort, finish;

    always_ff @(posedge PCLK or negedge nPOR) begin
        if (!nPOR) begin
            state      <= IDLE;
            ldPend     <= 1'b0;
            cntPend    <= 1'b0;
            mtPend     <= 1'b0;
            opValid    <= 1'b0;
            opSel      <= OP_NONE;
            timeoutErr <= 1'b0;
            timer      <= '0;
        end else begin
            state      <= stateNext;
            ldPend     <= ldPendNext;
            cntPend    <= cntPendNext;
            mtPend     <= mtPendNext;
            opValid    <= opValidNext;
            opSel      <= opSelNext;
            timeoutErr <= timeoutErrNext;
            timer      <= timerNext;
        end
    end

    // New triggers always win over the launch clear; a finished offset op forces
    // recompute of RTC value and match data, an aborted op re-requests itself.
    always_comb begin
        launchSel      = ldPend ? OP_LD : cntPend ? OP_CNT : OP_MT;
        launch         = state == IDLE && (ldPend || cntPend || mtPend);
        done           = state == BUSY && bus.OpDone;
        abort          = state == BUSY && !bus.OpDone && timer == TW'(TIMEOUT - 1);
        finish         = done || abort;
        ldPendNext     = bus.WrenRTCLR || (ldPend && !(launch && launchSel == OP_LD))
                         || (abort && opSel == OP_LD);
        cntPendNext    = bus.CountEdge || (cntPend && !(launch && launchSel == OP_CNT))
                         || (done && opSel == OP_LD) || (abort && opSel == OP_CNT);
        mtPendNext     = bus.WrenRTCMR || (mtPend && !(launch && launchSel == OP_MT))
                         || (done && opSel == OP_LD) || (abort && opSel == OP_MT);
        stateNext      = launch ? BUSY : finish ? IDLE : state;
        opValidNext    = launch || (opValid && !finish);
        opSelNext      = launch ? launchSel : finish ? OP_NONE : opSel;
        timerNext      = launch ? '0 : state == BUSY ? timer + 1'b1 : timer;
        timeoutErrNext = abort || (timeoutErr && !bus.ErrClr);
    end

    assign bus.OpValid    = opValid;
    assign bus.OpSel      = opSel;
    assign bus.TimeoutErr = timeoutErr;
    assign bus.Busy       = state != IDLE || ldPend || cntPend || mtPend;

`ifdef RTC_SCHED_LOSTCNT_EN
    logic [LOST_W-1:0] lostCnt;

    always_ff @(posedge PCLK or negedge nPOR) begin
        if (!nPOR)
            lostCnt <= '0;
        else if (bus.CountEdge && cntPend && !(launch && launchSel == OP_CNT) && lostCnt != '1)
            lostCnt <= lostCnt + 1'b1;
    end

    assign bus.LostCnt = lostCnt;
`else
    assign bus.LostCnt = {LOST_W{1'b0}};
`endif
endmodule

// File: tb/tb_rtc_update_sched.sv
// tb_rtc_update_sched: table-driven trigger vectors with an op-order scoreboard, plus
// hand sequences for latency, preemption, timeout/retry, async reset and LostCnt.
module tb_rtc_update_sched;
    localparam int TIMEOUT = 16;
    localparam int LOST_W  = 8;

    typedef struct {
        logic       ld;
        logic       cnt;
        logic       mt;
        int         n;
        logic [5:0] ops;
    } vec_t;

    logic       PCLK = 1'b0;
    logic       nPOR = 1'b0;
    int         compared = 0;
    int         mismatched = 0;
    int         n;
    logic [1:0] expQ[$];
    vec_t       vecs[7];

    always #5 PCLK = ~PCLK;

    rtc_update_sched_if #(.LOST_W(LOST_W)) bus ();

    rtc_update_sched #(.TIMEOUT(TIMEOUT), .LOST_W(LOST_W)) dut (
        .PCLK(PCLK),
        .nPOR(nPOR),
        .bus (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic trig(input logic ld, input logic cnt, input logic mt);
        bus.WrenRTCLR = ld;
        bus.CountEdge = cnt;
        bus.WrenRTCMR = mt;
        @(negedge PCLK);
        bus.WrenRTCLR = 1'b0;
        bus.CountEdge = 1'b0;
        bus.WrenRTCMR = 1'b0;
    endtask

    // Answer every issued op after lat cycles, popping its expected OpSel from the scoreboard.
    task automatic serve(input int lat);
        int guard = 0;
        while (bus.Busy && guard < 400) begin
            if (bus.OpValid) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected op: got %b, none expected", bus.OpSel);
                end else
                    check("op order", bus.OpSel, expQ.pop_front());
                repeat (lat) @(negedge PCLK);
                bus.OpDone = 1'b1;
                @(negedge PCLK);
                bus.OpDone = 1'b0;
                check("op retired", bus.OpValid, 0);
            end else
                @(negedge PCLK);
            guard++;
        end
        if (guard >= 400) begin
            compared++;
            mismatched++;
            $display("FAIL serve: still Busy after %0d steps, expected idle", guard);
        end
        check("queue drained", expQ.size(), 0);
        expQ.delete();
    endtask

    // Leave OpDone low while OpValid holds; optionally pulse ErrClr/OpDone on the last BUSY cycle.
    task automatic holdBusy(input logic clr, input logic dn, output int cycles);
        cycles = 0;
        while (bus.OpValid && cycles < 100) begin
            cycles++;
            bus.ErrClr = clr && cycles == TIMEOUT;
            bus.OpDone = dn && cycles == TIMEOUT;
            @(negedge PCLK);
        end
        bus.ErrClr = 1'b0;
        bus.OpDone = 1'b0;
    endtask

`ifdef RTC_SCHED_LOSTCNT_EN
    task automatic drain();
        int guard = 0;
        while (bus.Busy && guard < 400) begin
            bus.OpDone = bus.OpValid;
            @(negedge PCLK);
            guard++;
        end
        bus.OpDone = 1'b0;
        check("drain idle", bus.Busy, 0);
    endtask
`endif

    initial begin
        bus.WrenRTCLR = 1'b0;
        bus.CountEdge = 1'b0;
        bus.WrenRTCMR = 1'b0;
        bus.OpDone    = 1'b0;
        bus.ErrClr    = 1'b0;
        vecs[0] = '{1'b0, 1'b1, 1'b0, 1, 6'b10_00_00};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1, 6'b11_00_00};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 3, 6'b01_10_11};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 3, 6'b01_10_11};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 2, 6'b10_11_00};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 3, 6'b01_10_11};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 3, 6'b01_10_11};

        repeat (3) @(negedge PCLK);
        check("reset OpValid", bus.OpValid, 0);
        check("reset OpSel", bus.OpSel, 0);
        check("reset Busy", bus.Busy, 0);
        check("reset TimeoutErr", bus.TimeoutErr, 0);
        check("reset LostCnt", bus.LostCnt, 0);
        nPOR = 1'b1;
        @(negedge PCLK);

        trig(1'b0, 1'b1, 1'b0);
        check("pending not yet issued", bus.OpValid, 0);
        check("pending makes Busy", bus.Busy, 1);
        @(negedge PCLK);
        check("latency OpValid", bus.OpValid, 1);
        check("latency OpSel", bus.OpSel, 2'b10);
        bus.OpDone = 1'b1;
        @(negedge PCLK);
        bus.OpDone = 1'b0;
        check("done OpValid", bus.OpValid, 0);
        check("done OpSel", bus.OpSel, 0);
        check("done Busy", bus.Busy, 0);
        bus.OpDone = 1'b1;
        @(negedge PCLK);
        bus.OpDone = 1'b0;
        @(negedge PCLK);
        check("OpDone in IDLE ignored", {bus.Busy, bus.OpValid}, 0);

        foreach (vecs[i]) begin
            for (int k = 0; k < vecs[i].n; k++) expQ.push_back(vecs[i].ops[5-2*k -: 2]);
            trig(vecs[i].ld, vecs[i].cnt, vecs[i].mt);
            serve(2);
        end

        expQ = '{2'b11, 2'b01, 2'b10, 2'b11};
        trig(1'b0, 1'b0, 1'b1);
        @(negedge PCLK);
        trig(1'b1, 1'b0, 1'b0);
        serve(1);

        trig(1'b0, 1'b1, 1'b0);
        @(negedge PCLK);
        holdBusy(1'b1, 1'b0, n);
        check("timeout BUSY cycles", n, TIMEOUT);
        check("timeout beats ErrClr", bus.TimeoutErr, 1);
        check("abort drops OpValid", bus.OpValid, 0);
        expQ.push_back(2'b10);
        serve(1);
        bus.ErrClr = 1'b1;
        @(negedge PCLK);
        bus.ErrClr = 1'b0;
        check("ErrClr clears", bus.TimeoutErr, 0);

        trig(1'b0, 1'b1, 1'b0);
        @(negedge PCLK);
        holdBusy(1'b0, 1'b1, n);
        check("done on last cycle BUSY cycles", n, TIMEOUT);
        check("done on timeout edge no error", bus.TimeoutErr, 0);
        check("done on timeout edge idle", bus.Busy, 0);

        trig(1'b0, 1'b1, 1'b0);
        @(negedge PCLK);
        holdBusy(1'b0, 1'b0, n);
        check("second timeout err", bus.TimeoutErr, 1);
        @(negedge PCLK);
        check("retry reissued", bus.OpSel, 2'b10);
        trig(1'b1, 1'b0, 1'b1);
        #2 nPOR = 1'b0;
        #1;
        check("async reset OpValid", bus.OpValid, 0);
        check("async reset OpSel", bus.OpSel, 0);
        check("async reset Busy", bus.Busy, 0);
        check("async reset TimeoutErr", bus.TimeoutErr, 0);
        @(negedge PCLK);
        nPOR = 1'b1;
        repeat (3) @(negedge PCLK);
        check("pending discarded by reset", {bus.Busy, bus.OpValid}, 0);

        trig(1'b0, 1'b1, 1'b0);
        @(negedge PCLK);
        bus.CountEdge = 1'b1;
        repeat (5) @(negedge PCLK);
        bus.CountEdge = 1'b0;
`ifdef RTC_SCHED_LOSTCNT_EN
        check("LostCnt coalesced", bus.LostCnt, 4);
`else
        check("LostCnt tied off", bus.LostCnt, 0);
`endif
        expQ = '{2'b10, 2'b10};
        serve(1);
`ifdef RTC_SCHED_LOSTCNT_EN
        bus.CountEdge = 1'b1;
        repeat (300) @(negedge PCLK);
        bus.CountEdge = 1'b0;
        drain();
        check("LostCnt saturates", bus.LostCnt, 255);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
